instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Assembles instruction symbols plus operand fields into 32-bit MIPS machine words. It is the inverse of the instruction-classification/decode path.
- Used by the program-loader path to fill instruction memory from the testbench or debug front end.
- Each word is encoded in one registered stage, then buffered in a small FIFO.
- Each emitted word is tagged with a sequential text-segment address starting at BASE_ADDR.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, 2 to 16.
- BASE_ADDR, 32'h0000_3000, address of the first emitted word.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  encoder can accept.
- in_instr  in  `WIDTH_INSTR  instruction symbol, from the shared instructions.v codes.
- in_rs / in_rt / in_rd  in  5 each  register fields.
- in_shamt  in  5  shift amount.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  J/JAL target field.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_code  out  32  encoded word.
- out_addr  out  32  address of out_code.
- err  out  1  one-cycle pulse: unknown symbol dropped.
- err_count  out  8  saturating count of dropped symbols.

Behaviour:
- Handshake and pipeline:
  - Transfer occurs when in_valid && in_ready at a clk edge.
  - The accepted word is encoded into stage register S (S_valid=1).
  - At the next edge, S is pushed into the FIFO and S_valid clears, unless a new word is accepted.
  - S is a pass-through stage; its push never stalls.
- Latency: accept at edge N → out_valid high after edge N+1 when the FIFO was empty (2 cycles).
- in_ready = (fifo_count + S_valid) < DEPTH. It is registered-path only, with no combinational dependence on out_ready or in_valid. The FIFO therefore never overflows.
- Pop occurs when out_valid && out_ready. A simultaneous push and pop leaves the count unchanged. Pop on empty is impossible because out_valid=0.
- out_code and out_addr are held stable while out_valid && !out_ready.
- Address counter:
  - Starts at BASE_ADDR.
  - Increments by 4 on each pop; out_addr always shows the head's address.
  - Wraps modulo 2^32.
  - Dropped symbols do not consume an address.
- R-type encoding (opcode 0; funct in hex):
  - SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07.
  - JR 08, JALR 09.
  - MFHI 10, MTHI 11, MFLO 12, MTLO 13.
  - MULT 18, MULTU 19, DIV 1a, DIVU 1b.
  - ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2a, SLTU 2b.
  - NOP = 32'h0000_0000 regardless of fields.
- I-type opcodes (hex):
  - ADDI 08, ADDIU 09, SLTI 0a, SLTIU 0b, ANDI 0c, ORI 0d, XORI 0e, LUI 0f.
  - LB 20, LH 21, LW 23, LBU 24, LHU 25, SB 28, SH 29, SW 2b.
  - BEQ 04, BNE 05, BLEZ 06, BGTZ 07.
  - BLTZ 01 with rt=0; BGEZ 01 with rt=1.
- J-type: J 02, JAL 03, with target = in_target.
- Forced-zero fields (the input value is ignored):
  - shamt=0 for every R-type except SLL/SRL/SRA.
  - rs=0 for SLL/SRL/SRA, LUI, MFHI, MFLO.
  - rt=0 for JR, JALR, BLEZ, BGTZ, MFHI, MFLO, MTHI, MTLO.
  - rd=0 for JR, MTHI, MTLO, MULT, MULTU, DIV, DIVU.
- Unknown symbol:
  - Accepted normally (it consumes a handshake).
  - Not pushed into the FIFO.
  - err pulses high for the cycle in which it would have been pushed.
  - err_count increments, saturating at 8'hFF.
- Reset (at any time, including mid-stream):
  - FIFO emptied and S_valid=0.
  - out_valid=0, out_code=0, out_addr=BASE_ADDR.
  - err=0, err_count=0, in_ready=1 in the cycle after reset deasserts.
  - Words in flight are discarded.

Test Plan:
- ADDU rs=1 rt=2 rd=3 → out_code 32'h0022_1821 at out_addr 32'h0000_3000, out_valid 2 cycles after accept.
- Stream ORI rt=1 imm=16'h1234, then BGEZ rs=5 imm=16'hFFFF, then JAL target=26'h000_0C00 → 32'h3401_1234 @3000, 32'h04A1_FFFF @3004, 32'h0C00_0C00 @3008.
- Forced fields: SLL rs=7 rt=3 rd=2 shamt=4 → 32'h0003_1100. JR rs=31 rt=5 rd=6 shamt=9 → 32'h03E0_0008.
- Backpressure: out_ready=0, in_valid=1 continuously → exactly 4 accepts, then in_ready=0. Raising out_ready drains 4 words in order with addresses 3000..300C and reasserts in_ready.
- Unknown symbol between two ADDUs → err single pulse, err_count=1, the ADDUs emitted at 3000 and 3004 with no gap.
- Assert reset with 3 words buffered → out_valid=0, out_addr=3000, err_count=0. The next accepted word is emitted at 3000.

Source files
------------

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: symbol + operand fields -> 32-bit machine word,
// one registered encode stage feeding a small output FIFO tagged with text addresses.

package instr_pkg;
   localparam int WIDTH_INSTR = 6;

   localparam logic [WIDTH_INSTR-1:0] I_NOP   = 6'd0,  I_SLL   = 6'd1,  I_SRL   = 6'd2,
                                      I_SRA   = 6'd3,  I_SLLV  = 6'd4,  I_SRLV  = 6'd5,
                                      I_SRAV  = 6'd6,  I_JR    = 6'd7,  I_JALR  = 6'd8,
                                      I_MFHI  = 6'd9,  I_MTHI  = 6'd10, I_MFLO  = 6'd11,
                                      I_MTLO  = 6'd12, I_MULT  = 6'd13, I_MULTU = 6'd14,
                                      I_DIV   = 6'd15, I_DIVU  = 6'd16, I_ADD   = 6'd17,
                                      I_ADDU  = 6'd18, I_SUB   = 6'd19, I_SUBU  = 6'd20,
                                      I_AND   = 6'd21, I_OR    = 6'd22, I_XOR   = 6'd23,
                                      I_NOR   = 6'd24, I_SLT   = 6'd25, I_SLTU  = 6'd26,
                                      I_ADDI  = 6'd27, I_ADDIU = 6'd28, I_SLTI  = 6'd29,
                                      I_SLTIU = 6'd30, I_ANDI  = 6'd31, I_ORI   = 6'd32,
                                      I_XORI  = 6'd33, I_LUI   = 6'd34, I_LB    = 6'd35,
                                      I_LH    = 6'd36, I_LW    = 6'd37, I_LBU   = 6'd38,
                                      I_LHU   = 6'd39, I_SB    = 6'd40, I_SH    = 6'd41,
                                      I_SW    = 6'd42, I_BEQ   = 6'd43, I_BNE   = 6'd44,
                                      I_BLEZ  = 6'd45, I_BGTZ  = 6'd46, I_BLTZ  = 6'd47,
                                      I_BGEZ  = 6'd48, I_J     = 6'd49, I_JAL   = 6'd50;
endpackage

module instr_encoder
   import instr_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH_INSTR-1:0] in_instr,
   input  logic [4:0]             in_rs,
   input  logic [4:0]             in_rt,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_shamt,
   input  logic [15:0]            in_imm,
   input  logic [25:0]            in_target,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_code,
   output logic [31:0]            out_addr,
   output logic                   err,
   output logic [7:0]             err_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {K_R, K_I, K_J} kind_t;

   kind_t       kind;
   logic        enc_known;
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sh;
   logic [31:0] enc_code;

   always_comb begin
      kind      = K_R;
      enc_known = 1'b1;
      op        = 6'h00;
      fn        = 6'h00;
      rs        = in_rs;
      rt        = in_rt;
      rd        = in_rd;
      sh        = 5'd0;
      case (in_instr)
         I_NOP:   begin rs = 5'd0; rt = 5'd0; rd = 5'd0; end
         I_SLL:   begin rs = 5'd0; sh = in_shamt; fn = 6'h00; end
         I_SRL:   begin rs = 5'd0; sh = in_shamt; fn = 6'h02; end
         I_SRA:   begin rs = 5'd0; sh = in_shamt; fn = 6'h03; end
         I_SLLV:  fn = 6'h04;
         I_SRLV:  fn = 6'h06;
         I_SRAV:  fn = 6'h07;
         I_JR:    begin rt = 5'd0; rd = 5'd0; fn = 6'h08; end
         I_JALR:  begin rt = 5'd0; fn = 6'h09; end
         I_MFHI:  begin rs = 5'd0; rt = 5'd0; fn = 6'h10; end
         I_MTHI:  begin rt = 5'd0; rd = 5'd0; fn = 6'h11; end
         I_MFLO:  begin rs = 5'd0; rt = 5'd0; fn = 6'h12; end
         I_MTLO:  begin rt = 5'd0; rd = 5'd0; fn = 6'h13; end
         I_MULT:  begin rd = 5'd0; fn = 6'h18; end
         I_MULTU: begin rd = 5'd0; fn = 6'h19; end
         I_DIV:   begin rd = 5'd0; fn = 6'h1a; end
         I_DIVU:  begin rd = 5'd0; fn = 6'h1b; end
         I_ADD:   fn = 6'h20;
         I_ADDU:  fn = 6'h21;
         I_SUB:   fn = 6'h22;
         I_SUBU:  fn = 6'h23;
         I_AND:   fn = 6'h24;
         I_OR:    fn = 6'h25;
         I_XOR:   fn = 6'h26;
         I_NOR:   fn = 6'h27;
         I_SLT:   fn = 6'h2a;
         I_SLTU:  fn = 6'h2b;
         I_ADDI:  begin kind = K_I; op = 6'h08; end
         I_ADDIU: begin kind = K_I; op = 6'h09; end
         I_SLTI:  begin kind = K_I; op = 6'h0a; end
         I_SLTIU: begin kind = K_I; op = 6'h0b; end
         I_ANDI:  begin kind = K_I; op = 6'h0c; end
         I_ORI:   begin kind = K_I; op = 6'h0d; end
         I_XORI:  begin kind = K_I; op = 6'h0e; end
         I_LUI:   begin kind = K_I; op = 6'h0f; rs = 5'd0; end
         I_LB:    begin kind = K_I; op = 6'h20; end
         I_LH:    begin kind = K_I; op = 6'h21; end
         I_LW:    begin kind = K_I; op = 6'h23; end
         I_LBU:   begin kind = K_I; op = 6'h24; end
         I_LHU:   begin kind = K_I; op = 6'h25; end
         I_SB:    begin kind = K_I; op = 6'h28; end
         I_SH:    begin kind = K_I; op = 6'h29; end
         I_SW:    begin kind = K_I; op = 6'h2b; end
         I_BEQ:   begin kind = K_I; op = 6'h04; end
         I_BNE:   begin kind = K_I; op = 6'h05; end
         I_BLEZ:  begin kind = K_I; op = 6'h06; rt = 5'd0; end
         I_BGTZ:  begin kind = K_I; op = 6'h07; rt = 5'd0; end
         // REGIMM branches select the condition through the rt field
         I_BLTZ:  begin kind = K_I; op = 6'h01; rt = 5'd0; end
         I_BGEZ:  begin kind = K_I; op = 6'h01; rt = 5'd1; end
         I_J:     begin kind = K_J; op = 6'h02; end
         I_JAL:   begin kind = K_J; op = 6'h03; end
         default: enc_known = 1'b0;
      endcase
   end

   always_comb begin
      case (kind)
         K_I:     enc_code = {op, rs, rt, in_imm};
         K_J:     enc_code = {op, in_target};
         default: enc_code = {6'h00, rs, rt, rd, sh, fn};
      endcase
   end

   logic          s_valid, s_known;
   logic [31:0]   s_code;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   addr;
   logic          accept, push, pop;

   // occupancy includes the encode stage so its push can never overflow the FIFO
   assign in_ready  = ({1'b0, count} + (CW+1)'(s_valid)) < DEPTH_V;
   assign out_valid = (count != '0);
   assign out_code  = out_valid ? mem[rd_ptr] : 32'h0;
   assign out_addr  = addr;
   assign accept    = in_valid & in_ready;
   assign push      = s_valid & s_known;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_code;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_valid   <= 1'b0;
         s_known   <= 1'b0;
         s_code    <= 32'h0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         addr      <= BASE_ADDR;
         err       <= 1'b0;
         err_count <= 8'h00;
      end else begin
         s_valid <= accept;
         if (accept) begin
            s_code  <= enc_code;
            s_known <= enc_known;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            addr   <= addr + 32'd4;
         end
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         err <= s_valid & ~s_known;
         if (s_valid && !s_known && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, latency, backpressure,
// unknown-symbol handling, error saturation and mid-stream reset.
module tb_instr_encoder;
   import instr_pkg::*;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, err;
   logic [5:0]  in_instr;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic [31:0] out_code, out_addr;
   logic [7:0]  err_count;

   instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .out_addr(out_addr), .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  instr;
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[16];
   int   tests = 0;
   int   fails = 0;

   logic [31:0] q_code[$];
   logic [31:0] q_addr[$];
   int          err_pulses = 0;

   // monitor samples 1 time unit before each rising edge
   always begin
      @(negedge clk);
      #4;
      if (out_valid && out_ready) begin
         q_code.push_back(out_code);
         q_addr.push_back(out_addr);
      end
      if (err) err_pulses++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_fields(input vec_t v);
      in_instr  = v.instr;
      in_rs     = v.rs;
      in_rt     = v.rt;
      in_rd     = v.rd;
      in_shamt  = v.sh;
      in_imm    = v.imm;
      in_target = v.tgt;
   endtask

   task automatic send(input vec_t v);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
      end
      set_fields(v);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_words(input int target);
      int n = 0;
      while (q_code.size() < target && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q_code.size() < target) begin
         tests++; fails++;
         $display("FAIL wait_words: got %0d words expected %0d", q_code.size(), target);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] i, input logic [4:0] s, input logic [4:0] t,
                               input logic [4:0] d, input logic [4:0] h, input logic [15:0] m,
                               input logic [25:0] g, input logic [31:0] e);
      vec_t v;
      v.instr = i; v.rs = s; v.rt = t; v.rd = d; v.sh = h; v.imm = m; v.tgt = g; v.exp = e;
      return v;
   endfunction

   initial begin
      int base, ebase, acc;
      logic r;
      vec_t v;

      tbl[0]  = mk(I_ORI,  5'd0,  5'd1,  5'd0,  5'd0,  16'h1234, 26'd0,        32'h3401_1234);
      tbl[1]  = mk(I_BGEZ, 5'd5,  5'd7,  5'd0,  5'd0,  16'hFFFF, 26'd0,        32'h04A1_FFFF);
      tbl[2]  = mk(I_JAL,  5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h000_0C00, 32'h0C00_0C00);
      tbl[3]  = mk(I_SLL,  5'd7,  5'd3,  5'd2,  5'd4,  16'h0,    26'd0,        32'h0003_1100);
      tbl[4]  = mk(I_JR,   5'd31, 5'd5,  5'd6,  5'd9,  16'h0,    26'd0,        32'h03E0_0008);
      tbl[5]  = mk(I_NOP,  5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 32'h0000_0000);
      tbl[6]  = mk(I_LW,   5'd2,  5'd9,  5'd0,  5'd0,  16'h0010, 26'd0,        32'h8C49_0010);
      tbl[7]  = mk(I_MULT, 5'd4,  5'd5,  5'd6,  5'd3,  16'h0,    26'd0,        32'h0085_0018);
      tbl[8]  = mk(I_MFHI, 5'd3,  5'd4,  5'd8,  5'd0,  16'h0,    26'd0,        32'h0000_4010);
      tbl[9]  = mk(I_LUI,  5'd3,  5'd7,  5'd0,  5'd0,  16'hABCD, 26'd0,        32'h3C07_ABCD);
      tbl[10] = mk(I_BLTZ, 5'd2,  5'd9,  5'd0,  5'd0,  16'h0004, 26'd0,        32'h0440_0004);
      tbl[11] = mk(I_SRA,  5'd1,  5'd2,  5'd3,  5'd31, 16'h0,    26'd0,        32'h0002_1FC3);
      tbl[12] = mk(I_BLEZ, 5'd6,  5'd3,  5'd0,  5'd0,  16'h8000, 26'd0,        32'h18C0_8000);
      tbl[13] = mk(I_J,    5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h3FF_FFFF, 32'h0BFF_FFFF);
      tbl[14] = mk(I_SUB,  5'd31, 5'd31, 5'd31, 5'd5,  16'h0,    26'd0,        32'h03FF_F822);
      tbl[15] = mk(I_ADDU, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'd0,        32'h0022_1821);

      in_valid = 1'b0; out_ready = 1'b0;
      set_fields(tbl[5]);
      do_reset();

      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_code", out_code, 32'h0);
      check("rst_out_addr", out_addr, 32'h3000);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_err_count", {24'd0, err_count}, 32'd0);

      // latency: accept at edge N, out_valid visible after edge N+1
      out_ready = 1'b0;
      set_fields(tbl[15]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("lat_n_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("lat_n1_valid", {31'd0, out_valid}, 32'd1);
      check("lat_code", out_code, 32'h0022_1821);
      check("lat_addr", out_addr, 32'h3000);

      do_reset();
      out_ready = 1'b1;
      base = q_code.size();
      for (int i = 0; i < 16; i++) begin
         send(tbl[i]);
         wait_words(base + i + 1);
         if (q_code.size() > base + i) begin
            check($sformatf("tbl%0d_code", i), q_code[base+i], tbl[i].exp);
            check($sformatf("tbl%0d_addr", i), q_addr[base+i], 32'h3000 + 32'(4*i));
         end
      end

      // backpressure: continuous input with consumer stalled
      do_reset();
      out_ready = 1'b0;
      acc = 0;
      v = mk(I_ADDU, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0, 32'h0);
      set_fields(v);
      in_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         r = in_ready;
         in_rd = 5'(acc);
         @(negedge clk);
         if (r) acc++;
      end
      in_valid = 1'b0;
      check("bp_accepts", 32'(acc), 32'd4);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_stall_code", out_code, 32'h0000_0021);
      check("bp_stall_addr", out_addr, 32'h3000);
      base = q_code.size();
      out_ready = 1'b1;
      wait_words(base + 4);
      for (int k = 0; k < 4; k++) begin
         if (q_code.size() > base + k) begin
            check($sformatf("bp%0d_code", k), q_code[base+k], 32'h0000_0021 + 32'(k * 32'h800));
            check($sformatf("bp%0d_addr", k), q_addr[base+k], 32'h3000 + 32'(4*k));
         end
      end
      @(negedge clk);
      check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);

      // unknown symbol between two words
      do_reset();
      out_ready = 1'b1;
      base  = q_code.size();
      ebase = err_pulses;
      send(tbl[15]);
      send(mk(6'd60, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'd1, 32'h0));
      send(mk(I_ADDU, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'd0, 32'h0));
      wait_words(base + 2);
      repeat (4) @(negedge clk);
      check("unk_err_pulses", 32'(err_pulses - ebase), 32'd1);
      check("unk_err_count", {24'd0, err_count}, 32'd1);
      check("unk_words", 32'(q_code.size() - base), 32'd2);
      if (q_code.size() >= base + 2) begin
         check("unk_w0_code", q_code[base], 32'h0022_1821);
         check("unk_w0_addr", q_addr[base], 32'h3000);
         check("unk_w1_code", q_code[base+1], 32'h0085_3021);
         check("unk_w1_addr", q_addr[base+1], 32'h3004);
      end

      // error counter saturation
      do_reset();
      for (int k = 0; k < 260; k++) send(mk(6'd63, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0, 32'h0));
      repeat (3) @(negedge clk);
      check("err_sat", {24'd0, err_count}, 32'h0000_00FF);
      check("err_sat_no_words", {31'd0, out_valid}, 32'd0);

      // reset with words buffered
      do_reset();
      out_ready = 1'b0;
      send(mk(6'd61, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0, 32'h0));
      send(tbl[15]); send(tbl[0]); send(tbl[1]);
      repeat (3) @(negedge clk);
      check("pre_rst_err_count", {24'd0, err_count}, 32'd1);
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_addr", out_addr, 32'h3000);
      check("mid_rst_code", out_code, 32'h0);
      check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      base = q_code.size();
      out_ready = 1'b1;
      send(tbl[14]);
      wait_words(base + 1);
      repeat (3) @(negedge clk);
      check("post_rst_words", 32'(q_code.size() - base), 32'd1);
      if (q_code.size() > base) begin
         check("post_rst_code", q_code[base], 32'h03FF_F822);
         check("post_rst_addr", q_addr[base], 32'h3000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
